// File: rtl/shift_mac_pe.sv
// Shift-based MAC cell: power-of-two weight times activation, saturating/wrapping accumulate, drain chain.
// Latency: 1 cycle for pass-through, accumulate and drain hop.
// Backpressure: none; accepts a fire every cycle, with no stall.
module shift_mac_pe #(
    parameter int DATA_W   = 8,
    parameter int SHIFT_W  = 3,
    parameter int ACC_W    = 20,
    parameter bit SATURATE = 1'b1,
    localparam int CODE_W  = SHIFT_W + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] up_in,
    input  logic              up_valid_in,
    input  logic [DATA_W-1:0] left_in,
    input  logic              left_valid_in,
    input  logic              clear,
    input  logic              drain,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [CODE_W-1:0] up_out,
    output logic              up_valid_out,
    output logic [DATA_W-1:0] left_out,
    output logic              left_valid_out,
    output logic [ACC_W-1:0]  mat_out,
    output logic              ovf
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic               code_zero;
    logic               code_sign;
    logic [SHIFT_W-1:0] code_shift;
    logic               fire;
    logic [ACC_W-1:0]   act_ext;
    logic [ACC_W-1:0]   shifted;
    logic [ACC_W-1:0]   product;
    logic [ACC_W:0]     sum_wide;
    logic               sum_ovf;
    logic [ACC_W-1:0]   sum_res;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_d;

    assign code_zero  = up_in[SHIFT_W+1];
    assign code_sign  = up_in[SHIFT_W];
    assign code_shift = up_in[SHIFT_W-1:0];
    assign fire       = up_valid_in & left_valid_in & ~code_zero;

    // ACC_W >= DATA_W + 2^SHIFT_W keeps the shifted product exact, so no guard bits needed here
    assign act_ext = {{(ACC_W-DATA_W){left_in[DATA_W-1]}}, left_in};
    assign shifted = act_ext << code_shift;
    assign product = code_sign ? -shifted : shifted;

    // One extra bit exposes signed overflow as a mismatch of the top two sum bits
    assign sum_wide = {mat_out[ACC_W-1], mat_out} + {product[ACC_W-1], product};
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        sum_res = sum_wide[ACC_W-1:0];
        if (SATURATE && sum_ovf) begin
            sum_res = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        acc_d = mat_out;
        ovf_d = ovf;
        if (drain) begin
            acc_d = psum_in;
        end else if (clear) begin
            acc_d = fire ? product : '0;
            ovf_d = 1'b0;
        end else if (fire) begin
            acc_d = sum_res;
            ovf_d = ovf | sum_ovf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_out         <= '0;
            up_valid_out   <= 1'b0;
            left_out       <= '0;
            left_valid_out <= 1'b0;
            mat_out        <= '0;
            ovf            <= 1'b0;
        end else begin
            up_out         <= up_in;
            up_valid_out   <= up_valid_in;
            left_out       <= left_in;
            left_valid_out <= left_valid_in;
            mat_out        <= acc_d;
            ovf            <= ovf_d;
        end
    end
endmodule

// File: tb/tb_shift_mac_pe.sv
// Bench for shift_mac_pe: saturating and wrapping cells plus a 4-row drain column, scoreboard-checked.
module tb_shift_mac_pe;
    localparam longint MAXV = 524287;
    localparam longint MINV = -524288;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  up_in = '0;
    logic        up_valid_in = 1'b0;
    logic [7:0]  left_in = '0;
    logic        left_valid_in = 1'b0;
    logic        clear = 1'b0;
    logic        drain = 1'b0;
    logic [19:0] psum = '0;

    logic [4:0]  s_up, w_up;
    logic        s_uv, w_uv, s_lv, w_lv, s_ovf, w_ovf;
    logic [7:0]  s_lf, w_lf;
    logic [19:0] s_mat, w_mat;

    logic [7:0]  col_left [4];
    logic        col_lv = 1'b0;
    logic        col_clear = 1'b0;
    logic        col_drain = 1'b0;
    logic [4:0]  col_up_in [4];
    logic        col_uv_in [4];
    logic [19:0] col_ps_in [4];
    logic [4:0]  col_upo [4];
    logic        col_uvo [4];
    logic [7:0]  col_lo [4];
    logic        col_lvo [4];
    logic [19:0] col_mat [4];
    logic        col_ovf [4];

    always #5 clk = ~clk;

    shift_mac_pe #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .up_in(up_in), .up_valid_in(up_valid_in),
        .left_in(left_in), .left_valid_in(left_valid_in), .clear(clear), .drain(drain),
        .psum_in(psum), .up_out(s_up), .up_valid_out(s_uv), .left_out(s_lf),
        .left_valid_out(s_lv), .mat_out(s_mat), .ovf(s_ovf));

    shift_mac_pe #(.SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .up_in(up_in), .up_valid_in(up_valid_in),
        .left_in(left_in), .left_valid_in(left_valid_in), .clear(clear), .drain(drain),
        .psum_in(psum), .up_out(w_up), .up_valid_out(w_uv), .left_out(w_lf),
        .left_valid_out(w_lv), .mat_out(w_mat), .ovf(w_ovf));

    assign col_up_in[0] = up_in;
    assign col_uv_in[0] = up_valid_in;
    assign col_ps_in[0] = '0;
    for (genvar r = 0; r < 4; r++) begin : g_col
        if (r > 0) begin : g_link
            assign col_up_in[r] = col_upo[r-1];
            assign col_uv_in[r] = col_uvo[r-1];
            assign col_ps_in[r] = col_mat[r-1];
        end
        shift_mac_pe u_pe (
            .clk(clk), .reset_n(reset_n), .up_in(col_up_in[r]), .up_valid_in(col_uv_in[r]),
            .left_in(col_left[r]), .left_valid_in(col_lv), .clear(col_clear), .drain(col_drain),
            .psum_in(col_ps_in[r]), .up_out(col_upo[r]), .up_valid_out(col_uvo[r]),
            .left_out(col_lo[r]), .left_valid_out(col_lvo[r]), .mat_out(col_mat[r]), .ovf(col_ovf[r]));
    end

    typedef struct {
        longint            sat_m;
        bit                sat_o;
        longint            wrap_m;
        bit                wrap_o;
        logic [4:0]        up;
        bit                uv;
        logic [7:0]        lf;
        bit                lv;
        logic [3:0][63:0]  col_m;
        logic [4:0]        col_up3;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_err = 0;

    // Reference state: accumulators as plain integers
    longint     m_sat, m_wrap;
    bit         o_sat, o_wrap;
    longint     c_acc [4];
    bit         c_ovf [4];
    logic [4:0] c_code [4];
    bit         c_uv [4];

    function automatic void chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void pe_step(input longint acc_i, input bit ovf_i, input logic [4:0] code,
                                    input bit uv, input logic [7:0] left, input bit lv,
                                    input bit clr, input bit drn, input longint ps, input bit sat,
                                    output longint acc_o, output bit ovf_o);
        longint prod, s;
        bit     fire;
        fire  = uv && lv && !code[4];
        prod  = longint'($signed(left)) * (longint'(1) << code[2:0]);
        if (code[3]) prod = -prod;
        acc_o = acc_i;
        ovf_o = ovf_i;
        if (drn) begin
            acc_o = ps;
        end else if (clr) begin
            acc_o = fire ? prod : 0;
            ovf_o = 1'b0;
        end else if (fire) begin
            s = acc_i + prod;
            if (s > MAXV || s < MINV) begin
                ovf_o = 1'b1;
                if (sat) acc_o = (s > MAXV) ? MAXV : MINV;
                else     acc_o = (s > MAXV) ? s - 1048576 : s + 1048576;
            end else begin
                acc_o = s;
            end
        end
    endfunction

    function automatic void model_reset();
        m_sat = 0; m_wrap = 0; o_sat = 0; o_wrap = 0;
        for (int r = 0; r < 4; r++) begin
            c_acc[r] = 0; c_ovf[r] = 0; c_code[r] = '0; c_uv[r] = 0;
        end
    endfunction

    // Inputs are already applied; advance the model one edge and queue the expected outputs
    task automatic drive();
        exp_t       e;
        longint     nacc [4];
        bit         novf [4];
        logic [4:0] in_code;
        bit         in_uv;
        longint     in_ps;
        pe_step(m_sat, o_sat, up_in, up_valid_in, left_in, left_valid_in, clear, drain,
                longint'($signed(psum)), 1'b1, m_sat, o_sat);
        pe_step(m_wrap, o_wrap, up_in, up_valid_in, left_in, left_valid_in, clear, drain,
                longint'($signed(psum)), 1'b0, m_wrap, o_wrap);
        for (int r = 0; r < 4; r++) begin
            in_code = (r == 0) ? up_in : c_code[r-1];
            in_uv   = (r == 0) ? up_valid_in : c_uv[r-1];
            in_ps   = (r == 0) ? 0 : c_acc[r-1];
            pe_step(c_acc[r], c_ovf[r], in_code, in_uv, col_left[r], col_lv, col_clear, col_drain,
                    in_ps, 1'b1, nacc[r], novf[r]);
        end
        for (int r = 3; r > 0; r--) begin
            c_code[r] = c_code[r-1];
            c_uv[r]   = c_uv[r-1];
        end
        c_code[0] = up_in;
        c_uv[0]   = up_valid_in;
        for (int r = 0; r < 4; r++) begin
            c_acc[r] = nacc[r];
            c_ovf[r] = novf[r];
            e.col_m[r] = c_acc[r];
        end
        e.sat_m = m_sat;  e.sat_o = o_sat;
        e.wrap_m = m_wrap; e.wrap_o = o_wrap;
        e.up = up_in; e.uv = up_valid_in; e.lf = left_in; e.lv = left_valid_in;
        e.col_up3 = c_code[3];
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic op(input logic [7:0] lf, input bit lv, input bit z, input bit sg,
                      input logic [2:0] sh, input bit uv, input bit clr, input bit drn,
                      input logic [19:0] ps);
        left_in = lf; left_valid_in = lv; up_in = {z, sg, sh}; up_valid_in = uv;
        clear = clr; drain = drn; psum = ps;
        drive();
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_sat_mat"}, 64'(s_mat), 0);
        chk({tag, "_sat_ovf"}, 64'(s_ovf), 0);
        chk({tag, "_wrap_mat"}, 64'(w_mat), 0);
        chk({tag, "_wrap_ovf"}, 64'(w_ovf), 0);
        chk({tag, "_up_out"}, 64'(s_up), 0);
        chk({tag, "_up_valid"}, 64'(s_uv), 0);
        chk({tag, "_left_out"}, 64'(s_lf), 0);
        chk({tag, "_left_valid"}, 64'(s_lv), 0);
        for (int r = 0; r < 4; r++) begin
            chk({tag, "_col_mat"}, 64'(col_mat[r]), 0);
            chk({tag, "_col_uvo"}, 64'(col_uvo[r]), 0);
        end
    endtask

    // Monitor: every edge that has a queued expectation is compared just after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sat_mat", longint'($signed(s_mat)), e.sat_m);
                chk("sat_ovf", 64'(s_ovf), 64'(e.sat_o));
                chk("wrap_mat", longint'($signed(w_mat)), e.wrap_m);
                chk("wrap_ovf", 64'(w_ovf), 64'(e.wrap_o));
                chk("up_out", 64'(s_up), 64'(e.up));
                chk("up_valid_out", 64'(s_uv), 64'(e.uv));
                chk("left_out", 64'(w_lf), 64'(e.lf));
                chk("left_valid_out", 64'(w_lv), 64'(e.lv));
                for (int r = 0; r < 4; r++)
                    chk("col_mat", longint'($signed(col_mat[r])), $signed(e.col_m[r]));
                chk("col_up_out3", 64'(col_upo[3]), 64'(e.col_up3));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 4; r++) col_left[r] = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Signed accumulate, non-fire, saturation/wrap, priority
        op(8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 20'd0);
        op(8'd5,  1, 0, 0, 3'd3, 1, 0, 0, 20'd0);
        op(8'hFD, 1, 0, 1, 3'd1, 1, 0, 0, 20'd0);
        op(8'h80, 1, 0, 0, 3'd7, 1, 0, 0, 20'd0);
        op(8'h11, 1, 1, 0, 3'd2, 1, 0, 0, 20'd0);
        op(8'h22, 1, 0, 0, 3'd2, 0, 0, 0, 20'd0);
        op(8'h00, 0, 0, 0, 3'd0, 0, 0, 1, 20'd524000);
        op(8'd127, 1, 0, 0, 3'd7, 1, 0, 0, 20'd0);
        op(8'd1,  1, 0, 0, 3'd0, 1, 0, 0, 20'd0);
        op(8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 20'd0);
        op(8'h00, 0, 0, 0, 3'd0, 0, 0, 1, 20'd100);
        op(8'd7,  1, 0, 0, 3'd2, 1, 1, 0, 20'd0);
        op(8'h00, 0, 0, 0, 3'd0, 0, 0, 1, 20'd524000);
        op(8'd127, 1, 0, 0, 3'd7, 1, 0, 0, 20'd0);
        op(8'd7,  1, 0, 0, 3'd2, 1, 1, 1, 20'h123);
        op(8'h00, 0, 0, 0, 3'd0, 0, 1, 0, 20'd0);

        // Column: clear, load rows 10..40, then drain four cycles
        col_clear = 1'b1;
        op(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 20'd0);
        col_clear = 1'b0;
        repeat (5) op(8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 20'd0);
        for (int r = 0; r < 4; r++) col_left[r] = 8'(10 * (r + 1));
        col_lv = 1'b1;
        op(8'h00, 0, 0, 0, 3'd0, 1, 0, 0, 20'd0);
        col_lv = 1'b0;
        col_drain = 1'b1;
        repeat (4) op(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 20'd0);
        col_drain = 1'b0;
        repeat (2) op(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 20'd0);

        // Randomized traffic
        repeat (1500) begin
            left_in       = 8'($urandom);
            left_valid_in = ($urandom_range(0, 3) != 0);
            up_in         = 5'($urandom);
            up_valid_in   = ($urandom_range(0, 3) != 0);
            clear         = ($urandom_range(0, 19) == 0);
            drain         = ($urandom_range(0, 29) == 0);
            psum          = ($urandom_range(0, 1) == 1) ? 20'($urandom)
                                                        : 20'(MAXV - longint'($urandom_range(0, 20000)));
            for (int r = 0; r < 4; r++) col_left[r] = 8'($urandom);
            col_lv    = ($urandom_range(0, 2) != 0);
            col_clear = ($urandom_range(0, 24) == 0);
            col_drain = ($urandom_range(0, 9) == 0);
            drive();
        end

        // Asynchronous reset in the middle of accumulation
        col_lv = 1'b0; col_clear = 1'b0; col_drain = 1'b0;
        op(8'd5, 1, 0, 0, 3'd3, 1, 0, 1, 20'd1000);
        op(8'd5, 1, 0, 0, 3'd3, 1, 0, 0, 20'd0);
        op(8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 20'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("held_rst");
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        op(8'hF0, 1, 0, 1, 3'd4, 1, 0, 0, 20'd0);
        op(8'd3,  1, 0, 0, 3'd0, 1, 0, 0, 20'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
